stream_rr_arbiter: RTL and testbench

Parametrised N-channel arbiter that merges pixel/data streams from `NUM_CH` slave producers into the single FIFO write port feeding the processing core. It generalises the two-slave arbiter with fair round-robin selection, a per-grant burst limit, a registered output stage and a source tag. Backpressure comes from `fifo_full` and `mstr_cmplt`. All inputs are flattened vectors, with channel i in slice i.

---
 rtl/stream_rr_arbiter.sv | 170 +++++++++++++++++
 tb/tb_stream_rr_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// N-channel round-robin stream arbiter feeding a single FIFO write port.
// Define ARB_BURST_LOCK_EN to hold each grant for up to BURST_LEN beats; otherwise grants rotate per beat.
module stream_rr_arbiter #(
    parameter  int NUM_CH    = 4,
    parameter  int DW        = 32,
    parameter  int PW        = 8,
    parameter  int BURST_LEN = 16,
    localparam int SW        = $clog2(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2*NUM_CH-1:0]  slv_mode,
    input  logic [DW*NUM_CH-1:0] slv_data,
    input  logic [NUM_CH-1:0]    slv_data_valid,
    input  logic [PW*NUM_CH-1:0] slv_proc_val,
    output logic [NUM_CH-1:0]    slv_ready,
    input  logic                 fifo_full,
    input  logic                 mstr_cmplt,
    output logic [1:0]           slvx_mode,
    output logic [DW-1:0]        slvx_data,
    output logic [PW-1:0]        slvx_proc_val,
    output logic                 slvx_data_valid,
    output logic [SW-1:0]        data_source
);

    if (NUM_CH < 2 || BURST_LEN < 1) begin : g_param_check
        $error("stream_rr_arbiter: NUM_CH must be >= 2 and BURST_LEN >= 1");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state, state_nxt;
    logic [SW-1:0]      gnt, gnt_nxt, last, last_nxt;
    logic [NUM_CH-1:0]  elig;
    logic               can_acc, any_elig, xfer, burst_done, release_gnt;
    logic [1:0]         gnt_mode;
    logic               gnt_valid;
    logic [DW-1:0]      gnt_data;
    logic [PW-1:0]      gnt_proc;
    logic [SW-1:0]      pick_last, pick_gnt;

    // First requester strictly after base, wrapping; base itself is checked last.
    function automatic logic [SW-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                              input logic [SW-1:0] base);
        logic [SW-1:0] sel;
        logic [SW-1:0] pos;
        logic          found;
        sel   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            pos = SW'((32'(base) + k) % NUM_CH);
            if (!found && req[pos]) begin
                sel   = pos;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign can_acc   = ~fifo_full & ~mstr_cmplt;
    assign any_elig  = |elig;
    assign pick_last = rr_pick(elig, last);
    assign pick_gnt  = rr_pick(elig, gnt);
    assign xfer      = |(slv_ready & slv_data_valid);

    always_comb begin
        elig      = '0;
        slv_ready = '0;
        gnt_mode  = '0;
        gnt_valid = 1'b0;
        gnt_data  = '0;
        gnt_proc  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            elig[i]      = (slv_mode[2*i +: 2] != 2'b00) && slv_data_valid[i];
            slv_ready[i] = (state == GRANT) && (gnt == SW'(i)) &&
                           (slv_mode[2*i +: 2] != 2'b00) && can_acc;
            if (gnt == SW'(i)) begin
                gnt_mode  = slv_mode[2*i +: 2];
                gnt_valid = slv_data_valid[i];
                gnt_data  = slv_data[DW*i +: DW];
                gnt_proc  = slv_proc_val[PW*i +: PW];
            end
        end
    end

`ifdef ARB_BURST_LOCK_EN
    localparam int CW = $clog2(BURST_LEN + 1);
    logic [CW-1:0] cnt, cnt_nxt;
    assign burst_done = xfer && ((cnt + 1'b1) == CW'(BURST_LEN));
`else
    assign burst_done = xfer;
`endif

    // A stall blocks the low-valid release, but a dropped mode always releases.
    assign release_gnt = (gnt_mode == 2'b00) || (!gnt_valid && can_acc) || burst_done;

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        last_nxt  = last;
`ifdef ARB_BURST_LOCK_EN
        cnt_nxt   = cnt;
`endif
        case (state)
            IDLE: begin
                if (any_elig && can_acc) begin
                    gnt_nxt   = pick_last;
                    state_nxt = GRANT;
`ifdef ARB_BURST_LOCK_EN
                    cnt_nxt   = '0;
`endif
                end
            end
            GRANT: begin
`ifdef ARB_BURST_LOCK_EN
                if (xfer) cnt_nxt = cnt + 1'b1;
`endif
                if (release_gnt) begin
                    last_nxt = gnt;
                    if (any_elig && can_acc) begin
                        gnt_nxt = pick_gnt;
`ifdef ARB_BURST_LOCK_EN
                        cnt_nxt = '0;
`endif
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            last  <= SW'(NUM_CH - 1);
`ifdef ARB_BURST_LOCK_EN
            cnt   <= '0;
`endif
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            last  <= last_nxt;
`ifdef ARB_BURST_LOCK_EN
            cnt   <= cnt_nxt;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slvx_mode       <= '0;
            slvx_data       <= '0;
            slvx_proc_val   <= '0;
            slvx_data_valid <= 1'b0;
            data_source     <= '0;
        end else begin
            slvx_data_valid <= xfer;
            if (xfer) begin
                slvx_mode     <= gnt_mode;
                slvx_data     <= gnt_data;
                slvx_proc_val <= gnt_proc;
                data_source   <= gnt;
            end
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed table-driven bench for stream_rr_arbiter (4 channels, BURST_LEN=4).
// Expectations follow ARB_BURST_LOCK_EN when it is defined for the build.
module tb_stream_rr_arbiter;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int PW  = 8;
    localparam int BL  = 4;
`ifdef ARB_BURST_LOCK_EN
    localparam bit L = 1'b1;
`else
    localparam bit L = 1'b0;
`endif

    logic               clk   = 1'b0;
    logic               rst_n = 1'b1;
    logic [2*NCH-1:0]   slv_mode;
    logic [DW*NCH-1:0]  slv_data;
    logic [NCH-1:0]     slv_data_valid;
    logic [PW*NCH-1:0]  slv_proc_val;
    logic [NCH-1:0]     slv_ready;
    logic               fifo_full;
    logic               mstr_cmplt;
    logic [1:0]         slvx_mode;
    logic [DW-1:0]      slvx_data;
    logic [PW-1:0]      slvx_proc_val;
    logic               slvx_data_valid;
    logic [1:0]         data_source;

    stream_rr_arbiter #(.NUM_CH(NCH), .DW(DW), .PW(PW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst_n(rst_n),
        .slv_mode(slv_mode), .slv_data(slv_data), .slv_data_valid(slv_data_valid),
        .slv_proc_val(slv_proc_val), .slv_ready(slv_ready),
        .fifo_full(fifo_full), .mstr_cmplt(mstr_cmplt),
        .slvx_mode(slvx_mode), .slvx_data(slvx_data), .slvx_proc_val(slvx_proc_val),
        .slvx_data_valid(slvx_data_valid), .data_source(data_source)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit         rst;
        string      tag;
        logic [3:0] men;
        logic [3:0] vld;
        logic       full;
        logic       cmplt;
        logic [3:0] rdy;
        logic       dv;
        logic [1:0] src;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [1:0] ch_mode(input int i);
        case (i)
            0:       return 2'd1;
            1:       return 2'd2;
            2:       return 2'd3;
            default: return 2'd1;
        endcase
    endfunction

    function automatic logic [31:0] ch_data(input int i);
        return 32'hA5A5_0001 + 32'(i) * 32'h0001_0000;
    endfunction

    function automatic logic [7:0] ch_proc(input int i);
        return 8'h10 + 8'(i);
    endfunction

    function automatic void add(input string tag, input logic [3:0] men, input logic [3:0] vld,
                                input logic full, input logic cmplt, input logic [3:0] rdy,
                                input logic dv, input logic [1:0] src);
        vec_t v;
        v.rst = 1'b0; v.tag = tag; v.men = men; v.vld = vld; v.full = full;
        v.cmplt = cmplt; v.rdy = rdy; v.dv = dv; v.src = src;
        tbl.push_back(v);
    endfunction

    function automatic void add_rst(input string tag);
        vec_t v;
        v = '{rst: 1'b1, tag: tag, men: '0, vld: '0, full: 1'b0, cmplt: 1'b0,
              rdy: '0, dv: 1'b0, src: '0};
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] men, input logic [3:0] vld,
                         input logic full, input logic cmplt);
        for (int i = 0; i < NCH; i++) begin
            slv_mode[2*i +: 2]      = men[i] ? ch_mode(i) : 2'b00;
            slv_data[DW*i +: DW]    = ch_data(i);
            slv_proc_val[PW*i +: PW] = ch_proc(i);
        end
        slv_data_valid = vld;
        fifo_full      = full;
        mstr_cmplt     = cmplt;
    endtask

    // One cycle: ready is checked in the cycle, the registered beat after the edge.
    task automatic step(input string tag, input logic [3:0] men, input logic [3:0] vld,
                        input logic full, input logic cmplt, input logic [3:0] rdy,
                        input logic dv, input logic [1:0] src);
        drive(men, vld, full, cmplt);
        #1;
        check({tag, " ready"}, 32'(slv_ready), 32'(rdy));
        @(posedge clk);
        #1;
        check({tag, " strobe"}, 32'(slvx_data_valid), 32'(dv));
        if (dv) begin
            check({tag, " source"}, 32'(data_source), 32'(src));
            check({tag, " data"}, slvx_data, ch_data(int'(src)));
            check({tag, " mode"}, 32'(slvx_mode), 32'(ch_mode(int'(src))));
            check({tag, " proc"}, 32'(slvx_proc_val), 32'(ch_proc(int'(src))));
        end
    endtask

    // Reset is asserted with the current inputs still applied; outputs must clear at once.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, " rst ready"}, 32'(slv_ready), 32'h0);
        check({tag, " rst strobe"}, 32'(slvx_data_valid), 32'h0);
        check({tag, " rst data"}, slvx_data, 32'h0);
        check({tag, " rst src"}, 32'(data_source), 32'h0);
        check({tag, " rst mode/proc"}, {22'h0, slvx_mode, slvx_proc_val}, 32'h0);
        drive(4'h0, 4'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(4'h0, 4'h0, 1'b0, 1'b0);

        add_rst("A");
        add("A_idle", 4'h1, 4'h1, 0, 0, 4'h0, 0, 2'd0);
        add("A_beat", 4'h1, 4'h1, 0, 0, 4'h1, 1, 2'd0);
        add("A_lowv", 4'h1, 4'h0, 0, 0, 4'h1, 0, 2'd0);
        add("A_off",  4'h0, 4'h0, 0, 0, 4'h0, 0, 2'd0);

        add_rst("B");
        add("B_idle", 4'hF, 4'hF, 0, 0, 4'h0, 0, 2'd0);
        add("B_k0",   4'hF, 4'hF, 0, 0, 4'h1,           1, 2'd0);
        add("B_k1",   4'hF, 4'hF, 0, 0, L ? 4'h1 : 4'h2, 1, L ? 2'd0 : 2'd1);
        add("B_k2",   4'hF, 4'hF, 0, 0, L ? 4'h1 : 4'h4, 1, L ? 2'd0 : 2'd2);
        add("B_k3",   4'hF, 4'hF, 0, 0, L ? 4'h1 : 4'h8, 1, L ? 2'd0 : 2'd3);
        add("B_k4",   4'hF, 4'hF, 0, 0, L ? 4'h2 : 4'h1, 1, L ? 2'd1 : 2'd0);
        add("B_k5",   4'hF, 4'hF, 0, 0, 4'h2,            1, 2'd1);
        add("B_k6",   4'hF, 4'hF, 0, 0, L ? 4'h2 : 4'h4, 1, L ? 2'd1 : 2'd2);
        add("B_k7",   4'hF, 4'hF, 0, 0, L ? 4'h2 : 4'h8, 1, L ? 2'd1 : 2'd3);
        add("B_k8",   4'hF, 4'hF, 0, 0, L ? 4'h4 : 4'h1, 1, L ? 2'd2 : 2'd0);

        add_rst("C");
        add("C_idle",  4'h3, 4'h3, 0, 0, 4'h0, 0, 2'd0);
        add("C_b1",    4'h3, 4'h3, 0, 0, 4'h1, 1, 2'd0);
        add("C_b2",    4'h3, 4'h3, 0, 0, L ? 4'h1 : 4'h2, 1, L ? 2'd0 : 2'd1);
        add("C_full1", 4'h3, 4'h3, 1, 0, 4'h0, 0, 2'd0);
        add("C_full2", 4'h3, 4'h3, 1, 0, 4'h0, 0, 2'd0);
        add("C_full3", 4'h3, 4'h3, 1, 0, 4'h0, 0, 2'd0);
        add("C_b3",    4'h3, 4'h3, 0, 0, 4'h1, 1, 2'd0);
        add("C_b4",    4'h3, 4'h3, 0, 0, L ? 4'h1 : 4'h2, 1, L ? 2'd0 : 2'd1);
        add("C_b5",    4'h3, 4'h3, 0, 0, L ? 4'h2 : 4'h1, 1, L ? 2'd1 : 2'd0);

        add_rst("D");
        add("D_idle",  4'h2, 4'h2, 0, 0, 4'h0, 0, 2'd0);
        add("D_b1",    4'h2, 4'h2, 0, 0, 4'h2, 1, 2'd1);
        add("D_drop",  4'h4, 4'h6, 0, 0, 4'h0, 0, 2'd0);
        add("D_skip",  4'h4, 4'h6, 0, 0, 4'h4, 1, 2'd2);
        add("D_back",  4'h6, 4'h6, 0, 0, 4'h4, 1, 2'd2);
        add("D_after", 4'h6, 4'h6, 0, 0, L ? 4'h4 : 4'h2, 1, L ? 2'd2 : 2'd1);

        add_rst("E");
        add("E_cmp1",  4'hF, 4'hF, 0, 1, 4'h0, 0, 2'd0);
        add("E_cmp2",  4'hF, 4'hF, 0, 1, 4'h0, 0, 2'd0);
        add("E_rel",   4'hF, 4'hF, 0, 0, 4'h0, 0, 2'd0);
        add("E_gnt",   4'hF, 4'hF, 0, 0, 4'h1, 1, 2'd0);

        foreach (tbl[i]) begin
            if (tbl[i].rst)
                do_reset(tbl[i].tag);
            else
                step(tbl[i].tag, tbl[i].men, tbl[i].vld, tbl[i].full, tbl[i].cmplt,
                     tbl[i].rdy, tbl[i].dv, tbl[i].src);
        end

        // Reset in the middle of a ch2 burst, then ch0 must win first.
        do_reset("F");
        step("F_idle", 4'h4, 4'h4, 0, 0, 4'h0, 0, 2'd0);
        step("F_b1",   4'h4, 4'h4, 0, 0, 4'h4, 1, 2'd2);
        step("F_b2",   4'h4, 4'h4, 0, 0, 4'h4, 1, 2'd2);
        do_reset("F_mid");
        step("F_re_idle", 4'hF, 4'hF, 0, 0, 4'h0, 0, 2'd0);
        step("F_re_gnt",  4'hF, 4'hF, 0, 0, 4'h1, 1, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
